booth_divider: RTL
==================

BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 SHALL have parameter DW, default 16: dividend and quotient width in bits.
REQ-002 SHALL have parameter VW, default 8: divisor and remainder width in bits (VW <= DW).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, DW: signed two's-complement dividend.
REQ-007 SHALL have port divisor, input, VW: signed two's-complement divisor.
REQ-008 SHALL have port quotient, output, DW: signed quotient, registered.
REQ-009 SHALL have port remainder, output, VW: signed remainder, registered.
REQ-010 SHALL have port busy, output, 1: high while a division is in progress.
REQ-011 SHALL have port flag, output, 1: result valid; held until the next accepted start.
REQ-012 SHALL have port dz, output, 1: the last result was a divide-by-zero.
REQ-013 SHALL have port ovf, output, 1: the last result overflowed (most-negative dividend / -1).

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-015 SHALL, on an IDLE edge with start=1 (edge E0): latch the operands; store their magnitudes (divisor magnitude kept VW+1 bits so -2^(VW-1) is representable); record the result sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign); clear flag, dz and ovf; set busy=1.
REQ-016 SHALL, when the latched divisor is 0 at E0, skip CALC and go to DONE.
REQ-017 SHALL, for a non-zero divisor, go from E0 to CALC with the iteration counter = DW.
REQ-018 SHALL, in CALC, perform one restoring-division step per edge, MSB first: shift the partial remainder left by 1 and bring in the next dividend-magnitude bit; if partial remainder >= divisor magnitude, subtract and set the quotient bit to 1, else set it to 0; decrement the counter.
REQ-019 SHALL leave CALC for DONE on the edge that performs the DW-th step (edge E0+DW).
REQ-020 SHALL, on the DONE edge: apply the signs (negate the quotient magnitude if the result sign is 1; negate the remainder magnitude if the dividend was negative); register quotient and remainder; set flag=1 and busy=0; return to IDLE.
REQ-021 SHALL therefore assert flag after edge E0+DW+1 (17 edges at the defaults) for a normal division, and after edge E0+1 for divide-by-zero.
REQ-022 SHALL truncate the quotient toward zero; the remainder SHALL take the dividend's sign, with |remainder| < |divisor|.
REQ-023 SHALL, on divide-by-zero, give quotient=0, remainder=0, dz=1, ovf=0.
REQ-024 SHALL, for dividend = -2^(DW-1) and divisor = -1, give quotient = -2^(DW-1) (wrapped), remainder=0, ovf=1.
REQ-025 SHALL ignore start while busy=1; operand changes during CALC SHALL NOT affect the result.
REQ-026 SHALL keep quotient, remainder, dz and ovf stable from flag rising until the next accepted start.
REQ-027 SHALL make an accepted start clear flag on that same edge.
REQ-028 SHALL accept start in the same cycle flag is high, since the FSM is back in IDLE.

Reset
REQ-029 SHALL, on an edge with rst=1: go to IDLE and set quotient=0, remainder=0, busy=0, flag=0, dz=0, ovf=0, counter=0.
REQ-030 SHALL let rst take priority over start and over any state, including mid-CALC; the aborted division SHALL produce no flag.

Verification
REQ-031 SHALL cover: 100 / 7 -> quotient=14, remainder=2, flag high 17 edges after start, dz=0, ovf=0.
REQ-032 SHALL cover: -100 / 7 -> quotient=-14, remainder=-2; and 1000 / -13 -> quotient=-76, remainder=12.
REQ-033 SHALL cover: -32768 / -1 -> quotient=-32768 (16'h8000), remainder=0, ovf=1; and -32768 / -128 -> quotient=256, remainder=0, ovf=0.
REQ-034 SHALL cover: 55 / 0 -> flag after edge E0+1, dz=1, quotient=0, remainder=0.
REQ-035 SHALL cover: start 100/7, then at E0+3 change the operands and pulse start -> start ignored, result still 14 r 2.
REQ-036 SHALL cover: start, then assert rst at E0+5 -> all outputs 0, no flag; a following 100/7 completes correctly.

Source files
------------

// File: rtl/booth_divider.sv
// booth_divider: multi-cycle signed restoring divider.
// Operands are reduced to magnitudes on start, one quotient bit is produced
// per clock (MSB first), and signs are re-applied in a final DONE cycle.
// Quotient truncates toward zero; the remainder carries the dividend's sign.
module booth_divider #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          flag,
  output logic          dz,
  output logic          ovf
);

  // Partial remainder / divisor magnitude width: one extra bit so that the
  // magnitude of the most negative divisor (2^(VW-1)) and the shifted
  // partial remainder both fit.
  localparam int unsigned PW = VW + 1;
  // Shifted partial remainder width (partial remainder plus incoming bit).
  localparam int unsigned SW = VW + 2;
  // Iteration counter width, large enough to hold DW.
  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [VW-1:0] MINUS_ONE = {VW{1'b1}};

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;

  // Working registers
  logic [DW-1:0] qmag_q;    // dividend magnitude shifting out, quotient shifting in
  logic [PW-1:0] pr_q;      // partial remainder magnitude
  logic [PW-1:0] bmag_q;    // divisor magnitude
  logic [CW-1:0] cnt_q;     // remaining iterations
  logic          qsign_q;   // quotient sign
  logic          rsign_q;   // remainder sign (dividend sign)
  logic          dz_p_q;    // pending divide-by-zero status
  logic          ovf_p_q;   // pending overflow status

  // Operand decode at the accepting edge
  logic [DW-1:0] amag_c;
  logic [PW-1:0] dvs_ext_c;
  logic [PW-1:0] bmag_c;
  logic          div_zero_c;
  logic          div_ovf_c;
  logic          accept_c;

  // One restoring step
  logic [SW-1:0] shifted_c;
  logic [SW-1:0] bmag_ext_c;
  logic          ge_c;
  logic [PW-1:0] pr_nx_c;
  logic [DW-1:0] qmag_nx_c;

  // Sign application for the final result
  logic [VW-1:0] rmag_c;
  logic [DW-1:0] q_signed_c;
  logic [VW-1:0] r_signed_c;

  // Operand magnitudes and special-case detection
  always_comb begin
    amag_c     = dividend[DW-1] ? (-dividend) : dividend;
    dvs_ext_c  = {divisor[VW-1], divisor};
    bmag_c     = divisor[VW-1] ? (-dvs_ext_c) : dvs_ext_c;
    div_zero_c = (divisor == '0);
    div_ovf_c  = (dividend == MOST_NEG) && (divisor == MINUS_ONE);
    accept_c   = (state_q == IDLE) && start;
  end

  // Single restoring-division step: shift in next dividend bit, trial subtract
  always_comb begin
    shifted_c  = {pr_q, qmag_q[DW-1]};
    bmag_ext_c = {1'b0, bmag_q};
    ge_c       = (shifted_c >= bmag_ext_c);
    pr_nx_c    = ge_c ? PW'(shifted_c - bmag_ext_c) : PW'(shifted_c);
    qmag_nx_c  = {qmag_q[DW-2:0], ge_c};
  end

  // Signed result from magnitudes
  always_comb begin
    rmag_c     = pr_q[VW-1:0];
    q_signed_c = qsign_q ? (-qmag_q) : qmag_q;
    r_signed_c = rsign_q ? (-rmag_c) : rmag_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = div_zero_c ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      qmag_q    <= '0;
      pr_q      <= '0;
      bmag_q    <= '0;
      cnt_q     <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      dz_p_q    <= 1'b0;
      ovf_p_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      flag      <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            // A zero divisor skips CALC; zeroed magnitudes give a 0 r 0 result
            qmag_q  <= div_zero_c ? '0 : amag_c;
            pr_q    <= '0;
            bmag_q  <= bmag_c;
            cnt_q   <= div_zero_c ? '0 : CW'(DW);
            qsign_q <= dividend[DW-1] ^ divisor[VW-1];
            rsign_q <= dividend[DW-1];
            dz_p_q  <= div_zero_c;
            ovf_p_q <= div_ovf_c;
            busy    <= 1'b1;
            flag    <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        CALC: begin
          qmag_q <= qmag_nx_c;
          pr_q   <= pr_nx_c;
          cnt_q  <= cnt_q - CW'(1);
        end
        DONE: begin
          quotient  <= q_signed_c;
          remainder <= r_signed_c;
          dz        <= dz_p_q;
          ovf       <= ovf_p_q;
          busy      <= 1'b0;
          flag      <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
